om_range_recorder: RTL and testbench
====================================

// Module: om_range_recorder
// PURPOSE
//  Producer side of the object-range buffer. Software (malloc/free hooks) posts an object's
//  first and last byte addresses as two config writes. This block pairs them and validates
//  them, then queues the pair. It drives the write port of the range buffer
//  (write-enable + first/last address) with a per-entry handshake.
//  It sits between the CSR/MMIO decode and the range buffer.
// PARAMETERS
//  FIFO_DEPTH    4      pending validated records; power of 2, >=2
//  REGION_NIBBLE 4'h8   required addr[31:28] of tracked heap region
// PORTS
//  clk_i        in   1   clock
//  rst_ni       in   1   asynchronous reset, active-low
//  cfg_valid_i  in   1   config write valid
//  cfg_sel_i    in   1   0 = first address, 1 = last address
//  cfg_data_i   in   32  address payload
//  cfg_ready_o  out  1   config write accepted when valid&ready
//  rec_ready_i  in   1   range buffer can take an entry this cycle
//  rec_en_o     out  1   write-enable to range buffer (one entry per cycle high)
//  rec_first_o  out  32  first address of head record
//  rec_last_o   out  32  last address of head record
//  err_o        out  1   one-cycle pulse: rejected config write
//  err_code_o   out  2   0 NONE, 1 LAST_NO_FIRST, 2 ORDER (last<first), 3 REGION; held until next err
//  busy_o       out  1   FSM in HAVE_FIRST or FIFO non-empty
// BEHAVIOUR
//  - Reset: FSM=IDLE, FIFO empty, held first=0. All outputs 0 except cfg_ready_o=1.
//  - cfg_ready_o = !fifo_full (combinational). A handshake is cfg_valid_i & cfg_ready_o.
//  - FSM IDLE, sel=0, data[31:28]==REGION_NIBBLE: latch first, go HAVE_FIRST.
//  - FSM IDLE, sel=0, region mismatch: err REGION; stay IDLE.
//  - FSM IDLE, sel=1: err LAST_NO_FIRST; stay IDLE.
//  - FSM HAVE_FIRST, sel=0: silently replace the latched first (region-checked; a mismatch
//    gives err REGION and goes IDLE).
//  - FSM HAVE_FIRST, sel=1: if region mismatch -> err REGION. Else if data<first (unsigned)
//    -> err ORDER. Otherwise push {first,data}. In all three cases go IDLE.
//    last==first is legal (1-byte object).
//  - err_o/err_code_o are registered: they update the cycle after the offending handshake.
//  - Drain: rec_en_o = !fifo_empty & rec_ready_i. rec_first_o/rec_last_o always show the
//    head (0 when empty). Pop on rec_en_o.
//  - Latency: a push on cycle N is visible at the head on N+1. Earliest rec_en_o is N+1.
//  - Simultaneous push and pop: allowed when not full; the count is unchanged.
//  - Full FIFO: no handshake, so no push. The FSM state and the latched first are kept.
//  - Pointer wrap: modulo FIFO_DEPTH. Order is strictly FIFO.
//  - Reset mid-operation: the pending first and all queued records are discarded.
// CONFIGURATION
//  OM_REC_STATS_EN defined: adds ports cnt_accept_o[15:0] and cnt_reject_o[15:0].
//    cnt_accept_o counts records pushed. cnt_reject_o counts err_o pulses.
//    Both saturate at 16'hFFFF and reset to 0.
//  OM_REC_STATS_EN undefined: no counter ports and no counter logic.
// STRUCTURE
//  om_pkg holds:
//    - om_rec_t struct {first[31:0], last[31:0]}
//    - om_err_e enum (NONE, LAST_NO_FIRST, ORDER, REGION)
//    - om_rec_state_e enum (IDLE, HAVE_FIRST)
//    - OM_REGION_NIBBLE constant
//  Sub-module om_rec_fifo: parametric synchronous FIFO of om_rec_t with push/pop/full/empty.
//  FSM and validation logic live in the top.
// TESTING
//  1. first=0x8000_0100, last=0x8000_01FF, rec_ready=1 -> one rec_en_o pulse with
//     {0x8000_0100,0x8000_01FF} the cycle after the last write.
//  2. last=0x8000_0010 with no prior first -> err_o pulse, code 1, no rec_en_o.
//  3. first=0x8000_0200, last=0x8000_01FF -> err code 2. A following last without a new
//     first -> code 1.
//  4. first=0x9000_0000 -> err code 3, FSM stays IDLE.
//  5. rec_ready=0 and 5 valid pairs (depth 4) -> cfg_ready_o low after the 4th push.
//     Then raising rec_ready drains in order, and the 5th pair completes.
//  6. rst_ni low while in HAVE_FIRST with 2 records queued -> empty, busy_o=0; a later
//     last gives err code 1. With OM_REC_STATS_EN: counters read 0.

Source files
------------

// File: rtl/om_pkg.sv
// om_pkg: shared types and constants for the object-range recorder
package om_pkg;
  typedef struct packed {
    logic [31:0] first;
    logic [31:0] last;
  } om_rec_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_LAST_NO_FIRST, ERR_ORDER, ERR_REGION} om_err_e;
  typedef enum logic {ST_IDLE, ST_HAVE_FIRST} om_rec_state_e;
  localparam logic [3:0] OM_REGION_NIBBLE = 4'h8;
endpackage

// File: rtl/om_rec_fifo.sv
// om_rec_fifo: synchronous FIFO of range records; head reads as zero when empty
module om_rec_fifo
  import om_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  om_rec_t din_i,
  input  logic    pop_i,
  output om_rec_t dout_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(DEPTH);
  om_rec_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din_i;
endmodule

// File: rtl/om_range_recorder.sv
// om_range_recorder: pairs/validates first+last config writes and queues records; OM_REC_STATS_EN adds counters
module om_range_recorder
  import om_pkg::*;
#(
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [3:0] REGION_NIBBLE = OM_REGION_NIBBLE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_valid_i,
  input  logic        cfg_sel_i,
  input  logic [31:0] cfg_data_i,
  output logic        cfg_ready_o,
  input  logic        rec_ready_i,
  output logic        rec_en_o,
  output logic [31:0] rec_first_o,
  output logic [31:0] rec_last_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
`ifdef OM_REC_STATS_EN
  ,
  output logic [15:0] cnt_accept_o,
  output logic [15:0] cnt_reject_o
`endif
);
  om_rec_state_e state_q;
  om_err_e err_c, err_q;
  om_rec_t head;
  logic [31:0] first_q;
  logic hs, region_ok, push, full, empty;
  assign cfg_ready_o = !full;
  assign hs          = cfg_valid_i && cfg_ready_o;
  assign region_ok   = cfg_data_i[31:28] == REGION_NIBBLE;
  assign rec_en_o    = !empty && rec_ready_i;
  assign rec_first_o = head.first;
  assign rec_last_o  = head.last;
  assign err_code_o  = err_q;
  assign busy_o      = state_q == ST_HAVE_FIRST || !empty;
  always_comb begin
    err_c = !hs ? ERR_NONE :
            (cfg_sel_i && state_q == ST_IDLE) ? ERR_LAST_NO_FIRST :
            !region_ok ? ERR_REGION :
            (cfg_sel_i && cfg_data_i < first_q) ? ERR_ORDER : ERR_NONE;
    push  = hs && cfg_sel_i && state_q == ST_HAVE_FIRST && err_c == ERR_NONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      first_q <= '0;
      err_o   <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      err_o <= err_c != ERR_NONE;
      if (err_c != ERR_NONE) err_q <= err_c;
      if (hs) begin
        state_q <= (!cfg_sel_i && region_ok) ? ST_HAVE_FIRST : ST_IDLE;
        if (!cfg_sel_i && region_ok) first_q <= cfg_data_i;
      end
    end
  om_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .din_i  ({first_q, cfg_data_i}),
    .pop_i  (rec_en_o),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );
`ifdef OM_REC_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_accept_o <= '0;
      cnt_reject_o <= '0;
    end else begin
      cnt_accept_o <= cnt_accept_o + 16'(push && cnt_accept_o != '1);
      cnt_reject_o <= cnt_reject_o + 16'(err_c != ERR_NONE && cnt_reject_o != '1);
    end
`endif
endmodule

// File: tb/tb_om_range_recorder.sv
// tb_om_range_recorder: table vectors, corner sequences and random traffic against a queue model
module tb_om_range_recorder;
  import om_pkg::*;
  localparam int FD = 4;
  logic clk_i = 0, rst_ni = 0, cfg_valid_i = 0, cfg_sel_i = 0, rec_ready_i = 0;
  logic [31:0] cfg_data_i = 0;
  logic cfg_ready_o, rec_en_o, err_o, busy_o;
  logic [31:0] rec_first_o, rec_last_o;
  logic [1:0] err_code_o;
`ifdef OM_REC_STATS_EN
  logic [15:0] cnt_accept_o, cnt_reject_o;
`endif
  om_range_recorder #(.FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_sel_i(cfg_sel_i),
    .cfg_data_i(cfg_data_i), .cfg_ready_o(cfg_ready_o), .rec_ready_i(rec_ready_i),
    .rec_en_o(rec_en_o), .rec_first_o(rec_first_o), .rec_last_o(rec_last_o),
    .err_o(err_o), .err_code_o(err_code_o), .busy_o(busy_o)
`ifdef OM_REC_STATS_EN
    , .cnt_accept_o(cnt_accept_o), .cnt_reject_o(cnt_reject_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  int errors = 0, checks = 0;
  om_rec_t mq[$], got[$];
  bit have, merr;
  logic [31:0] mfirst;
  logic [1:0] mcode;
  int macc, mrej;
  typedef struct {
    bit v, s;
    logic [31:0] d;
    bit busy, en;
    logic [31:0] f, l;
    bit err;
    logic [1:0] code;
  } vec_t;
  vec_t vt[14];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(bit v, bit s, logic [31:0] d, bit r, output bit ok);
    om_rec_t h;
    int e;
    bit pop;
    cfg_valid_i = v; cfg_sel_i = s; cfg_data_i = d; rec_ready_i = r;
    #1;
    h = mq.size() > 0 ? mq[0] : '0;
    chk("cfg_ready", cfg_ready_o, mq.size() < FD);
    chk("rec_en", rec_en_o, mq.size() > 0 && r);
    chk("rec_first", rec_first_o, h.first);
    chk("rec_last", rec_last_o, h.last);
    chk("err", err_o, merr);
    chk("err_code", err_code_o, mcode);
    chk("busy", busy_o, have || mq.size() > 0);
`ifdef OM_REC_STATS_EN
    chk("cnt_accept", cnt_accept_o, macc);
    chk("cnt_reject", cnt_reject_o, mrej);
`endif
    if (rec_en_o) got.push_back({rec_first_o, rec_last_o});
    ok = v && mq.size() < FD;
    pop = mq.size() > 0 && r;
    e = 0;
    if (ok) begin
      if (!s) begin
        if (d[31:28] == 4'h8) begin have = 1; mfirst = d; end
        else begin e = 3; have = 0; end
      end else begin
        if (!have) e = 1;
        else if (d[31:28] != 4'h8) e = 3;
        else if (d < mfirst) e = 2;
        else begin
          if (pop) mq.delete(0);
          pop = 0;
          mq.push_back({mfirst, d});
          macc++;
        end
        have = 0;
      end
    end
    if (pop) mq.delete(0);
    merr = e != 0;
    if (e != 0) begin mcode = 2'(e); mrej++; end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic idle(bit r);
    bit ok;
    cyc(0, 0, 0, r, ok);
  endtask
  task automatic send(bit s, logic [31:0] d, bit r);
    bit ok;
    int n = 0;
    do begin cyc(1, s, d, r, ok); n++; end while (!ok && n < 40);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake expected handshake within 40 cycles");
    end
  endtask
  task automatic do_reset();
    rst_ni = 0; cfg_valid_i = 0; rec_ready_i = 1;
    #1;
    chk("rst_cfg_ready", cfg_ready_o, 1);
    chk("rst_rec_en", rec_en_o, 0);
    chk("rst_first", rec_first_o, 0);
    chk("rst_last", rec_last_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_code", err_code_o, 0);
    chk("rst_busy", busy_o, 0);
`ifdef OM_REC_STATS_EN
    chk("rst_cnt_accept", cnt_accept_o, 0);
    chk("rst_cnt_reject", cnt_reject_o, 0);
`endif
    mq.delete(); have = 0; mfirst = 0; merr = 0; mcode = 0; macc = 0; mrej = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask
  initial begin
    bit ok;
    vt = '{
      '{1, 0, 32'h8000_0100, 0, 0, 0, 0, 0, 0},
      '{1, 1, 32'h8000_01FF, 1, 0, 0, 0, 0, 0},
      '{0, 0, 32'h0,         1, 1, 32'h8000_0100, 32'h8000_01FF, 0, 0},
      '{1, 1, 32'h8000_0010, 0, 0, 0, 0, 0, 0},
      '{0, 0, 32'h0,         0, 0, 0, 0, 1, 1},
      '{1, 0, 32'h8000_0200, 0, 0, 0, 0, 0, 1},
      '{1, 1, 32'h8000_01FF, 1, 0, 0, 0, 0, 1},
      '{0, 0, 32'h0,         0, 0, 0, 0, 1, 2},
      '{1, 1, 32'h8000_0300, 0, 0, 0, 0, 0, 2},
      '{0, 0, 32'h0,         0, 0, 0, 0, 1, 1},
      '{1, 0, 32'h9000_0000, 0, 0, 0, 0, 0, 1},
      '{0, 0, 32'h0,         0, 0, 0, 0, 1, 3},
      '{1, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 3},
      '{0, 0, 32'h0,         0, 0, 0, 0, 1, 1}
    };
    @(negedge clk_i);
    do_reset();
    foreach (vt[i]) begin
      cfg_valid_i = vt[i].v; cfg_sel_i = vt[i].s; cfg_data_i = vt[i].d; rec_ready_i = 1;
      #1;
      chk($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
      chk($sformatf("vec%0d_en", i), rec_en_o, vt[i].en);
      chk($sformatf("vec%0d_first", i), rec_first_o, vt[i].f);
      chk($sformatf("vec%0d_last", i), rec_last_o, vt[i].l);
      chk($sformatf("vec%0d_err", i), err_o, vt[i].err);
      chk($sformatf("vec%0d_code", i), err_code_o, vt[i].code);
      cyc(vt[i].v, vt[i].s, vt[i].d, 1, ok);
    end
    // Fill to full with the drain stalled, then drain and complete the fifth pair
    got.delete();
    for (int i = 1; i <= 4; i++) begin
      send(0, 32'h8000_0000 | (i << 12), 0);
      send(1, 32'h8000_00FF | (i << 12), 0);
    end
    #1;
    chk("full_ready_low", cfg_ready_o, 0);
    idle(0);
    send(0, 32'h8000_5000, 1);
    send(1, 32'h8000_50FF, 1);
    repeat (6) idle(1);
    chk("drain_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      chk($sformatf("drain%0d_first", i), got[i].first, 32'h8000_0000 | ((i + 1) << 12));
      chk($sformatf("drain%0d_last", i), got[i].last, 32'h8000_00FF | ((i + 1) << 12));
    end
    send(0, 32'h8000_0400, 1);
    send(1, 32'h8000_0400, 1);
    #1;
    chk("one_byte_head", rec_last_o, 32'h8000_0400);
    idle(1);
    // Reset while holding a first with two records queued
    send(0, 32'h8000_0600, 0);
    send(1, 32'h8000_06FF, 0);
    send(0, 32'h8000_0700, 0);
    send(1, 32'h8000_07FF, 0);
    send(0, 32'h8000_0800, 0);
    #1;
    chk("pre_rst_busy", busy_o, 1);
    do_reset();
    idle(1);
    send(1, 32'h8000_08FF, 1);
    idle(1);
    chk("post_rst_code", err_code_o, 1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = {($urandom_range(0, 7) == 0) ? 4'h9 : 4'h8, 20'h0, 8'($urandom)};
      cyc($urandom_range(0, 3) != 0, 1'($urandom), d, $urandom_range(0, 2) != 0, ok);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
